inst_fetch: RTL and testbench

Instruction fetch stage directly upstream of the decode stage. Holds the PC and issues in-order word requests to instruction memory. Buffers returned instructions in a small FIFO and presents {inst, pc} to decode over a valid/ready handshake. Redirects from execute (branch/jal/jalr resolution) flush the FIFO and squash in-flight responses.

---
 rtl/inst_fetch_pkg.sv | 26 ++
 rtl/inst_fetch_fifo.sv | 75 +++++++
 rtl/inst_fetch.sv | 135 +++++++++++++
 tb/tb_inst_fetch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared widths, the fetch-buffer entry layout and PC helpers for the fetch stage.
package inst_fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [ADDR_W-1:0] pc_align(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic pc_misaligned(input logic [ADDR_W-1:0] pc);
        return |pc[1:0];
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO with flush; used for the instruction buffer and the in-flight PC tags.
module inst_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == CW'(DEPTH));
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            wptr_d  = wptr_q + AW'(do_push);
            rptr_d  = rptr_q + AW'(do_pop);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC generation, credit-limited memory requests, response tagging,
// redirect flush/squash and the {inst, pc} handshake towards decode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_misalign
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic              misalign_q, misalign_d;

    logic              accept;
    logic              resp;
    logic [CW:0]       credit_used;

    logic              ibuf_push, ibuf_pop, ibuf_full, ibuf_empty;
    logic [CW-1:0]     ibuf_count;
    fetch_entry_t      ibuf_wdata, ibuf_head;

    logic [ADDR_W-1:0] tag_pc;
    logic [CW-1:0]     tag_count;
    logic              tag_full, tag_empty;

    // Every outstanding request owns a buffer slot; a slot leaving this cycle can be
    // reused at once because its response cannot arrive before the next cycle.
    always_comb begin
        resp        = imem_resp_valid;
        out_valid   = ~rst & ~ibuf_empty & ~redirect_valid;
        ibuf_pop    = out_valid & out_ready;
        credit_used = {1'b0, inflight_q} + {1'b0, ibuf_count} - {{CW{1'b0}}, ibuf_pop};
        imem_req_valid = ~rst & ~redirect_valid & ~misalign_q
                       & (credit_used < (CW+1)'(FIFO_DEPTH));
        imem_req_addr  = pc_q;
        accept         = imem_req_valid & imem_req_ready;
        ibuf_push      = resp & (drop_q == '0) & ~redirect_valid;
        ibuf_wdata     = '{pc: tag_pc, inst: imem_resp_data};
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(accept) - CW'(resp);
        drop_d     = drop_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            pc_d       = pc_align(redirect_pc);
            drop_d     = inflight_q - CW'(resp);
            misalign_d = pc_misaligned(redirect_pc);
        end else begin
            if (accept) begin
                pc_d = pc_q + PC_STEP;
            end
            if (resp && drop_q != '0) begin
                drop_d = drop_q - CW'(1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= pc_align(RESET_PC);
            inflight_q <= '0;
            drop_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            misalign_q <= misalign_d;
        end
    end

    inst_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (ibuf_push),
        .pop_i   (ibuf_pop),
        .wdata_i (ibuf_wdata),
        .rdata_o (ibuf_head),
        .count_o (ibuf_count),
        .full_o  (ibuf_full),
        .empty_o (ibuf_empty)
    );

    // Tags survive redirects so squashed responses still pop their own PC.
    inst_fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tagq (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .push_i  (accept),
        .pop_i   (resp),
        .wdata_i (pc_q),
        .rdata_o (tag_pc),
        .count_o (tag_count),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    assign out_inst     = ibuf_empty ? '0 : ibuf_head.inst;
    assign out_pc       = ibuf_empty ? '0 : ibuf_head.pc;
    assign out_misalign = misalign_q;

    a_resp_tracked: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (inflight_q != '0 && !tag_empty));

    a_tags_match: assert property (@(posedge clk) disable iff (rst)
        (tag_count == inflight_q) && !(tag_full && accept && !resp) && !(ibuf_full && ibuf_push && !ibuf_pop));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: memory model plus a scoreboard of expected {pc, inst}.
module tb_inst_fetch;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_misalign;

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .out_misalign    (out_misalign)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          hs_cnt = 0;
    int          acc_cnt = 0;
    int          lat = 1;
    int          cyc_m = 0;
    logic [31:0] first_addr = 32'hDEAD_BEEF;
    bit          arm_first = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t pend[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic expect_stream(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    // Memory: responds in order, lat cycles after accept; cleared by reset.
    always begin
        @(negedge clk);
        #2;
        cyc_m++;
        if (rst) begin
            pend.delete();
            imem_resp_valid = 1'b0;
            first_addr = 32'hDEAD_BEEF;
            arm_first = 1'b1;
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc_m) begin
                imem_resp_valid = 1'b1;
                imem_resp_data = pend[0].addr ^ K;
                void'(pend.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{addr: imem_req_addr, due: cyc_m + lat});
                acc_cnt++;
                if (arm_first) begin
                    first_addr = imem_req_addr;
                    arm_first = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every decode handshake must match the next expected entry.
    always begin
        @(negedge clk);
        #3;
        if (!rst && out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got pc=%h inst=%h, want no output", out_pc, out_inst);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_out_pc", out_pc, mon_e);
                check("sb_out_inst", out_inst, mon_e ^ K);
            end
        end
    end

    task automatic reset_dut(input logic rdy, input int latency);
        cyc();
        rst = 1'b1;
        out_ready = rdy;
        redirect_valid = 1'b0;
        lat = latency;
        exp_q.delete();
        cyc();
        #4;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_misalign", 32'(out_misalign), 32'd0);
        cyc();
        rst = 1'b0;
        expect_stream(32'h0, 64);
    endtask

    task automatic wait_out_pc(input logic [31:0] pc, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            #4;
            if (out_valid) begin
                seen = 1'b1;
                check(nm, out_pc, pc);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: got no out_valid in 40 cycles, want pc %h", nm, pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, h0;

        // Streaming with a 1-cycle memory
        reset_dut(1'b1, 1);
        cyc();
        cyc();
        #4;
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, 32'h0000_0000);
        check("first_inst", out_inst, 32'hA5A5_0000);
        cyc();
        #4;
        check("second_pc", out_pc, 32'h0000_0004);
        check("second_inst", out_inst, 32'hA5A5_0004);
        h0 = hs_cnt;
        repeat (10) cyc();
        #4;
        check("throughput_10", 32'(hs_cnt - h0), 32'd10);

        // Decode stalled: credit limit, then drain
        reset_dut(1'b0, 1);
        a0 = acc_cnt;
        h0 = hs_cnt;
        repeat (10) cyc();
        #4;
        check("stall_accepts", 32'(acc_cnt - a0), 32'd2);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_no_hs", 32'(hs_cnt - h0), 32'd0);
        check("stall_head_pc", out_pc, 32'h0000_0000);
        cyc();
        out_ready = 1'b1;
        h0 = hs_cnt;
        repeat (9) cyc();
        #4;
        check("drain_10", 32'(hs_cnt - h0), 32'd10);

        // 3-cycle memory, redirect with two requests in flight
        reset_dut(1'b1, 3);
        a0 = acc_cnt;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        exp_q.delete();
        expect_stream(32'h0000_0100, 32);
        #4;
        check("inflight_accepts", 32'(acc_cnt - a0), 32'd2);
        check("redir_out_valid", 32'(out_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        wait_out_pc(32'h0000_0100, "late_resp_dropped_pc");

        // Redirect coinciding with a response, followed by a second redirect
        reset_dut(1'b1, 1);
        repeat (5) cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0400;
        exp_q.delete();
        #4;
        check("redir_resp_present", 32'(imem_resp_valid), 32'd1);
        check("redir_no_valid", 32'(out_valid), 32'd0);
        h0 = hs_cnt;
        cyc();
        redirect_pc = 32'h0000_0500;
        exp_q.delete();
        expect_stream(32'h0000_0500, 32);
        #4;
        check("redir2_no_valid", 32'(out_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        #4;
        check("redir_no_hs", 32'(hs_cnt - h0), 32'd0);
        wait_out_pc(32'h0000_0500, "last_redirect_wins");

        // Misaligned target: sticky flag, fetch halts until next redirect
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        exp_q.delete();
        cyc();
        redirect_valid = 1'b0;
        #4;
        check("misalign_set", 32'(out_misalign), 32'd1);
        a0 = acc_cnt;
        repeat (6) cyc();
        #4;
        check("misalign_no_accepts", 32'(acc_cnt - a0), 32'd0);
        check("misalign_req_valid", 32'(imem_req_valid), 32'd0);
        check("misalign_out_valid", 32'(out_valid), 32'd0);
        check("misalign_sticky", 32'(out_misalign), 32'd1);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        exp_q.delete();
        expect_stream(32'h0000_0200, 32);
        cyc();
        redirect_valid = 1'b0;
        #4;
        check("misalign_cleared", 32'(out_misalign), 32'd0);
        wait_out_pc(32'h0000_0200, "resume_pc");

        // PC wrap at the top of the address space
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        exp_q.delete();
        expect_stream(32'hFFFF_FFF8, 32);
        cyc();
        redirect_valid = 1'b0;
        wait_out_pc(32'hFFFF_FFF8, "wrap_pc0");
        cyc();
        #4;
        check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        cyc();
        #4;
        check("wrap_pc2", out_pc, 32'h0000_0000);
        check("wrap_inst2", out_inst, 32'hA5A5_0000);

        // Reset while the buffer is full
        cyc();
        out_ready = 1'b0;
        repeat (4) cyc();
        #4;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        cyc();
        rst = 1'b1;
        exp_q.delete();
        #4;
        check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        expect_stream(32'h0, 32);
        #1;
        check("postrst_out_valid", 32'(out_valid), 32'd0);
        check("postrst_out_pc", out_pc, 32'd0);
        cyc();
        #4;
        check("postrst_first_addr", first_addr, 32'h0000_0000);
        wait_out_pc(32'h0000_0000, "postrst_first_out");

        repeat (5) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
